// File: rtl/class_oftcam_pkg.sv
// Shared definitions for the classifier overflow TCAM: result encodings,
// PIO address layout and table sizing helpers.
package class_oftcam_pkg;

    // Result encoding for rslt_hit_miss.
    localparam logic HIT  = 1'b1;
    localparam logic MISS = 1'b0;

    // PIO field selector, taken from address bits [7:6].
    typedef enum logic [1:0] {
        FLD_VALUE = 2'd0,
        FLD_MASK  = 2'd1,
        FLD_CTRL  = 2'd2,
        FLD_RSVD  = 2'd3
    } fld_e;

    // PIO address layout: {entry[15:8], field[7:6], word[5:0]}.
    localparam int PIO_DW        = 32;
    localparam int ADDR_W        = 16;
    localparam int ADDR_ENT_LSB  = 8;
    localparam int ADDR_ENT_W    = 8;
    localparam int ADDR_FLD_LSB  = 6;
    localparam int ADDR_FLD_W    = 2;
    localparam int ADDR_WORD_LSB = 0;
    localparam int ADDR_WORD_W   = 6;

    // Number of 32-bit PIO words needed to hold one key-sized field.
    function automatic int calc_words(input int key_len);
        return (key_len + 31) / 32;
    endfunction

    // Bits of the last PIO word that actually belong to the key; the rest
    // are discarded on write so they always read back as zero.
    function automatic logic [31:0] last_word_mask(input int key_len);
        int rem;
        rem = key_len % 32;
        if (rem == 0) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'h1 << rem) - 32'h1;
        end
    endfunction

endpackage

// File: rtl/class_oftcam_penc.sv
// Lowest-index priority encoder over the registered match vector, with
// any-hit and more-than-one-hit indications. Purely combinational.
module class_oftcam_penc
    import class_oftcam_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] match,
    output logic [IDX_W-1:0] idx,
    output logic             hit,
    output logic             multi
);

    // Scan from the top down so the lowest set index is the one left in idx.
    always_comb begin
        idx = {IDX_W{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = match[i] ? IDX_W'(i) : idx;
        end
    end

    assign hit = (|match) ? HIT : MISS;

    // Clearing the lowest set bit leaves something only when two or more
    // bits were set, which is exactly the multi-hit condition.
    assign multi = |(match & (match - DEPTH'(1)));

endmodule

// File: rtl/class_oftcam_tern.sv
// Ternary overflow TCAM for the classifier. DEPTH entries of value/mask/valid
// are compared against every key in parallel; a 3-stage pipeline returns the
// VID of the lowest matching entry. Table contents are accessed over the
// 32-bit PIO bus concurrently with lookups.
module class_oftcam_tern
    import class_oftcam_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int KEY_LEN   = 276,
    parameter int VID_WIDTH = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_vld,
    input  logic [KEY_LEN-1:0]   key,
    input  logic [VID_WIDTH-1:0] base_vid,
    output logic                 rslt_vld,
    output logic [VID_WIDTH-1:0] rslt_vid,
    output logic                 rslt_hit_miss,
    output logic                 rslt_err,
    input  logic                 pio_oftcam_rd,
    input  logic                 pio_oftcam_wr,
    input  logic [ADDR_W-1:0]    pio_oftcam_addr,
    input  logic [PIO_DW-1:0]    pio_oftcam_wrdata,
    output logic                 oftcam_pio_ack,
    output logic [PIO_DW-1:0]    oftcam_pio_rddata
);

    localparam int WORDS    = calc_words(KEY_LEN);
    localparam int PAD_LEN  = WORDS * 32;
    localparam int ENT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LAST_IDX = WORDS - 1;

    localparam logic [31:0]            LAST_MASK = last_word_mask(KEY_LEN);
    localparam logic [ADDR_ENT_W:0]    DEPTH_LIM = DEPTH[ADDR_ENT_W:0];
    localparam logic [ADDR_WORD_W:0]   WORDS_LIM = WORDS[ADDR_WORD_W:0];
    localparam logic [ADDR_WORD_W-1:0] LAST_WORD = LAST_IDX[ADDR_WORD_W-1:0];

    // ------------------------------------------------------------------
    // Table storage. Padding bits above KEY_LEN in the last word are never
    // written with ones, so they cannot influence a compare.
    // ------------------------------------------------------------------
    logic [31:0]      value_r [DEPTH][WORDS];
    logic [31:0]      mask_r  [DEPTH][WORDS];
    logic [DEPTH-1:0] valid_r;

    // ------------------------------------------------------------------
    // PIO address decode
    // ------------------------------------------------------------------
    logic [ADDR_ENT_W-1:0]  addr_ent_s;
    logic [ADDR_WORD_W-1:0] addr_word_s;
    fld_e                   addr_fld_s;
    logic [ENT_W-1:0]       ent_idx_s;
    logic [WORD_W-1:0]      word_idx_s;
    logic                   ent_ok_s;
    logic                   word_ok_s;
    logic                   acc_ok_s;
    logic                   wr_en_s;
    logic                   rd_only_s;
    logic                   strobe_s;
    logic [31:0]            wr_data_s;
    logic [31:0]            rd_data_s;

    assign addr_ent_s  = pio_oftcam_addr[ADDR_ENT_LSB +: ADDR_ENT_W];
    assign addr_word_s = pio_oftcam_addr[ADDR_WORD_LSB +: ADDR_WORD_W];
    assign addr_fld_s  = fld_e'(pio_oftcam_addr[ADDR_FLD_LSB +: ADDR_FLD_W]);
    assign ent_idx_s   = addr_ent_s[ENT_W-1:0];
    assign word_idx_s  = addr_word_s[WORD_W-1:0];

    // Range checks use the full address fields so that aliasing through
    // the truncated indices can never reach the table.
    assign ent_ok_s  = ({1'b0, addr_ent_s} < DEPTH_LIM);
    assign word_ok_s = ({1'b0, addr_word_s} < WORDS_LIM);
    assign acc_ok_s  = ent_ok_s & word_ok_s & (addr_fld_s != FLD_RSVD);

    // A simultaneous read and write is treated as a write only.
    assign wr_en_s   = pio_oftcam_wr & acc_ok_s;
    assign rd_only_s = pio_oftcam_rd & ~pio_oftcam_wr;
    assign strobe_s  = pio_oftcam_rd | pio_oftcam_wr;

    // Key bits beyond KEY_LEN are stripped from the last word on write.
    assign wr_data_s = pio_oftcam_wrdata &
                       ((addr_word_s == LAST_WORD) ? LAST_MASK : 32'hFFFF_FFFF);

    // Table update from PIO writes; lookups launched in the same cycle
    // still see the contents from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int e = 0; e < DEPTH; e++) begin
                for (int w = 0; w < WORDS; w++) begin
                    value_r[e][w] <= 32'h0;
                    mask_r[e][w]  <= 32'h0;
                end
            end
        end else if (wr_en_s) begin
            case (addr_fld_s)
                FLD_VALUE: value_r[ent_idx_s][word_idx_s] <= wr_data_s;
                FLD_MASK:  mask_r[ent_idx_s][word_idx_s]  <= wr_data_s;
                FLD_CTRL:  valid_r[ent_idx_s]             <= wr_data_s[0];
                default:   ;
            endcase
        end
    end

    // Read-data mux; anything out of range or reserved reads as zero.
    always_comb begin
        rd_data_s = 32'h0;
        if (acc_ok_s) begin
            case (addr_fld_s)
                FLD_VALUE: rd_data_s = value_r[ent_idx_s][word_idx_s];
                FLD_MASK:  rd_data_s = mask_r[ent_idx_s][word_idx_s];
                FLD_CTRL:  rd_data_s = {31'h0, valid_r[ent_idx_s]};
                default:   rd_data_s = 32'h0;
            endcase
        end else begin
            rd_data_s = 32'h0;
        end
    end

    // PIO response: one-cycle ack per strobe, read data held until the
    // next accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            oftcam_pio_ack    <= 1'b0;
            oftcam_pio_rddata <= 32'h0;
        end else begin
            oftcam_pio_ack <= strobe_s;
            if (rd_only_s) begin
                oftcam_pio_rddata <= rd_data_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Parallel ternary compare
    // ------------------------------------------------------------------
    logic [PAD_LEN-1:0] key_pad_s;
    logic [DEPTH-1:0]   match_s;

    assign key_pad_s = PAD_LEN'(key);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [PAD_LEN-1:0] val_flat_s;
        logic [PAD_LEN-1:0] msk_flat_s;

        for (genvar gw = 0; gw < WORDS; gw++) begin : g_word
            assign val_flat_s[gw*32 +: 32] = value_r[gi][gw];
            assign msk_flat_s[gw*32 +: 32] = mask_r[gi][gw];
        end

        // A zero mask bit is "don't care"; an all-zero mask is a wildcard.
        assign match_s[gi] = valid_r[gi] &
                             ~(|((key_pad_s ^ val_flat_s) & msk_flat_s));
    end

    // ------------------------------------------------------------------
    // Lookup pipeline: S1 match vector, S2 priority encode, S3 outputs
    // ------------------------------------------------------------------
    logic             s1_vld_r;
    logic [DEPTH-1:0] s1_match_r;
    logic             s2_vld_r;
    logic [ENT_W-1:0] s2_idx_r;
    logic             s2_hit_r;
    logic             s2_multi_r;
    logic [ENT_W-1:0] penc_idx_s;
    logic             penc_hit_s;
    logic             penc_multi_s;

    // S1: capture the match vector for the key presented this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r   <= 1'b0;
            s1_match_r <= {DEPTH{1'b0}};
        end else begin
            s1_vld_r   <= key_vld;
            s1_match_r <= match_s;
        end
    end

    class_oftcam_penc #(
        .DEPTH (DEPTH),
        .IDX_W (ENT_W)
    ) u_penc (
        .match (s1_match_r),
        .idx   (penc_idx_s),
        .hit   (penc_hit_s),
        .multi (penc_multi_s)
    );

    // S2: register the priority-encoded result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_r   <= 1'b0;
            s2_idx_r   <= {ENT_W{1'b0}};
            s2_hit_r   <= 1'b0;
            s2_multi_r <= 1'b0;
        end else begin
            s2_vld_r   <= s1_vld_r;
            s2_idx_r   <= penc_idx_s;
            s2_hit_r   <= penc_hit_s;
            s2_multi_r <= penc_multi_s;
        end
    end

    // S3: result registers; fields are zero on idle cycles and on misses.
    // base_vid is sampled here, so a change applies to keys leaving S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            rslt_vld      <= 1'b0;
            rslt_vid      <= {VID_WIDTH{1'b0}};
            rslt_hit_miss <= MISS;
            rslt_err      <= 1'b0;
        end else begin
            rslt_vld <= s2_vld_r;
            if (s2_vld_r && s2_hit_r) begin
                rslt_vid      <= base_vid + VID_WIDTH'(s2_idx_r);
                rslt_hit_miss <= HIT;
                rslt_err      <= s2_multi_r;
            end else begin
                rslt_vid      <= {VID_WIDTH{1'b0}};
                rslt_hit_miss <= MISS;
                rslt_err      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_class_oftcam_tern.sv
// Directed bench for class_oftcam_tern (DEPTH=16, KEY_LEN=276, VID_WIDTH=15).
module tb_class_oftcam_tern;

    localparam int DEPTH     = 16;
    localparam int KEY_LEN   = 276;
    localparam int VID_WIDTH = 15;
    localparam int WORDS     = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 key_vld;
    logic [KEY_LEN-1:0]   key;
    logic [VID_WIDTH-1:0] base_vid;
    logic                 rslt_vld;
    logic [VID_WIDTH-1:0] rslt_vid;
    logic                 rslt_hit_miss;
    logic                 rslt_err;
    logic                 pio_oftcam_rd;
    logic                 pio_oftcam_wr;
    logic [15:0]          pio_oftcam_addr;
    logic [31:0]          pio_oftcam_wrdata;
    logic                 oftcam_pio_ack;
    logic [31:0]          oftcam_pio_rddata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [KEY_LEN-1:0] k_a;
    logic [KEY_LEN-1:0] k_b;
    logic [KEY_LEN-1:0] ones;
    logic [31:0]        rd_val;

    always #5 clk = ~clk;

    class_oftcam_tern #(
        .DEPTH     (DEPTH),
        .KEY_LEN   (KEY_LEN),
        .VID_WIDTH (VID_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .key_vld           (key_vld),
        .key               (key),
        .base_vid          (base_vid),
        .rslt_vld          (rslt_vld),
        .rslt_vid          (rslt_vid),
        .rslt_hit_miss     (rslt_hit_miss),
        .rslt_err          (rslt_err),
        .pio_oftcam_rd     (pio_oftcam_rd),
        .pio_oftcam_wr     (pio_oftcam_wr),
        .pio_oftcam_addr   (pio_oftcam_addr),
        .pio_oftcam_wrdata (pio_oftcam_wrdata),
        .oftcam_pio_ack    (oftcam_pio_ack),
        .oftcam_pio_rddata (oftcam_pio_rddata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pio_write(input int ent, input int fld, input int wd, input logic [31:0] data);
        @(negedge clk);
        pio_oftcam_wr     = 1'b1;
        pio_oftcam_addr   = {ent[7:0], fld[1:0], wd[5:0]};
        pio_oftcam_wrdata = data;
        @(negedge clk);
        chk("wr_ack", 32'(oftcam_pio_ack), 32'd1);
        pio_oftcam_wr = 1'b0;
    endtask

    task automatic pio_read(input int ent, input int fld, input int wd, output logic [31:0] data);
        @(negedge clk);
        pio_oftcam_rd   = 1'b1;
        pio_oftcam_addr = {ent[7:0], fld[1:0], wd[5:0]};
        @(negedge clk);
        chk("rd_ack", 32'(oftcam_pio_ack), 32'd1);
        data          = oftcam_pio_rddata;
        pio_oftcam_rd = 1'b0;
    endtask

    task automatic write_entry(input int ent, input logic [KEY_LEN-1:0] val,
                               input logic [KEY_LEN-1:0] msk, input logic vld);
        logic [WORDS*32-1:0] v_pad;
        logic [WORDS*32-1:0] m_pad;
        v_pad = {12'h0, val};
        m_pad = {12'h0, msk};
        for (int w = 0; w < WORDS; w++) begin
            pio_write(ent, 0, w, v_pad[w*32 +: 32]);
            pio_write(ent, 1, w, m_pad[w*32 +: 32]);
        end
        pio_write(ent, 2, 0, {31'h0, vld});
    endtask

    // One key in an otherwise idle pipeline: checks the 3-cycle latency,
    // the result fields and that the fields drop back to zero afterwards.
    task automatic run_lookup(input string tag, input logic [KEY_LEN-1:0] k,
                              input logic [31:0] exp_hit, input logic [31:0] exp_vid,
                              input logic [31:0] exp_err);
        @(negedge clk);
        key     = k;
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_early"}, 32'(rslt_vld), 32'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 32'(rslt_vld), 32'd1);
        chk({tag, "_hit"}, 32'(rslt_hit_miss), exp_hit);
        chk({tag, "_vid"}, 32'(rslt_vid), exp_vid);
        chk({tag, "_err"}, 32'(rslt_err), exp_err);
        @(negedge clk);
        chk({tag, "_vld_after"}, 32'(rslt_vld), 32'd0);
        chk({tag, "_vid_idle"}, 32'(rslt_vid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        k_a  = {20'hABCDE, 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0};
        k_b  = ~k_a;
        ones = {KEY_LEN{1'b1}};

        rst               = 1'b1;
        key_vld           = 1'b0;
        key               = {KEY_LEN{1'b0}};
        base_vid          = 15'd0;
        pio_oftcam_rd     = 1'b0;
        pio_oftcam_wr     = 1'b0;
        pio_oftcam_addr   = 16'h0;
        pio_oftcam_wrdata = 32'h0;

        // Reset with strobes active: all outputs must stay at zero.
        repeat (2) @(negedge clk);
        key_vld       = 1'b1;
        key           = k_a;
        pio_oftcam_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(rslt_vld), 32'd0);
        chk("rst_vid", 32'(rslt_vid), 32'd0);
        chk("rst_hit", 32'(rslt_hit_miss), 32'd0);
        chk("rst_err", 32'(rslt_err), 32'd0);
        chk("rst_ack", 32'(oftcam_pio_ack), 32'd0);
        chk("rst_rddata", oftcam_pio_rddata, 32'h0);
        key_vld       = 1'b0;
        pio_oftcam_rd = 1'b0;
        rst           = 1'b0;

        // A key in flight when reset hits is dropped.
        @(negedge clk);
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop_vld", 32'(rslt_vld), 32'd0);
        end

        // Empty table: lookup misses, ctrl of entry 0 reads zero.
        run_lookup("empty", k_a, 32'd0, 32'd0, 32'd0);
        pio_read(0, 2, 0, rd_val);
        chk("ctrl0_rst", rd_val, 32'h0);

        // Exact entry 3 with base 100.
        base_vid = 15'd100;
        write_entry(3, k_a, ones, 1'b1);
        run_lookup("exact", k_a, 32'd1, 32'd103, 32'd0);
        run_lookup("exact_miss", k_a ^ 276'h1, 32'd0, 32'd0, 32'd0);

        // Wildcard entry 1 (value and mask still zero from reset).
        pio_write(1, 2, 0, 32'h1);
        run_lookup("multi", k_a, 32'd1, 32'd101, 32'd1);
        run_lookup("wild", k_a ^ 276'h1, 32'd1, 32'd101, 32'd0);

        // Back-to-back keys K, K^1, K with the wildcard disabled.
        pio_write(1, 2, 0, 32'h0);
        @(negedge clk);
        key = k_a;
        key_vld = 1'b1;
        @(negedge clk);
        key = k_a ^ 276'h1;
        @(negedge clk);
        key = k_a;
        @(negedge clk);
        key_vld = 1'b0;
        chk("burst0_vld", 32'(rslt_vld), 32'd1);
        chk("burst0_hit", 32'(rslt_hit_miss), 32'd1);
        chk("burst0_vid", 32'(rslt_vid), 32'd103);
        @(negedge clk);
        chk("burst1_vld", 32'(rslt_vld), 32'd1);
        chk("burst1_hit", 32'(rslt_hit_miss), 32'd0);
        chk("burst1_vid", 32'(rslt_vid), 32'd0);
        @(negedge clk);
        chk("burst2_vld", 32'(rslt_vld), 32'd1);
        chk("burst2_hit", 32'(rslt_hit_miss), 32'd1);
        chk("burst2_vid", 32'(rslt_vid), 32'd103);
        @(negedge clk);
        chk("burst_end_vld", 32'(rslt_vld), 32'd0);

        // Invalidate entry 3 in the same cycle as a lookup of K.
        @(negedge clk);
        key               = k_a;
        key_vld           = 1'b1;
        pio_oftcam_wr     = 1'b1;
        pio_oftcam_addr   = {8'd3, 2'd2, 6'd0};
        pio_oftcam_wrdata = 32'h0;
        @(negedge clk);
        chk("race_ack", 32'(oftcam_pio_ack), 32'd1);
        pio_oftcam_wr = 1'b0;
        @(negedge clk);
        key_vld = 1'b0;
        chk("race_ack_single", 32'(oftcam_pio_ack), 32'd0);
        @(negedge clk);
        chk("race_old_vld", 32'(rslt_vld), 32'd1);
        chk("race_old_hit", 32'(rslt_hit_miss), 32'd1);
        chk("race_old_vid", 32'(rslt_vid), 32'd103);
        @(negedge clk);
        chk("race_new_vld", 32'(rslt_vld), 32'd1);
        chk("race_new_hit", 32'(rslt_hit_miss), 32'd0);
        chk("race_new_vid", 32'(rslt_vid), 32'd0);

        // VID wrap: 0x7FFF + 2 -> 0x0001.
        base_vid = 15'h7FFF;
        write_entry(2, k_b, ones, 1'b1);
        run_lookup("wrap", k_b, 32'd1, 32'd1, 32'd0);

        // Out-of-range entry: acked, reads zero, no aliasing into entry 4.
        pio_write(20, 0, 0, 32'hDEAD_BEEF);
        pio_read(20, 0, 0, rd_val);
        chk("oor_ent_rd", rd_val, 32'h0);
        pio_read(4, 0, 0, rd_val);
        chk("oor_alias_rd", rd_val, 32'h0);
        run_lookup("oor_table", k_b, 32'd1, 32'd1, 32'd0);

        // Last-word truncation and read-back of stored words.
        pio_write(5, 0, 8, 32'hFFFF_FFFF);
        pio_read(5, 0, 8, rd_val);
        chk("last_word_val", rd_val, 32'h000F_FFFF);
        pio_read(2, 1, 8, rd_val);
        chk("last_word_msk", rd_val, 32'h000F_FFFF);
        pio_read(2, 0, 0, rd_val);
        chk("val_word0", rd_val, k_b[31:0]);

        // Word index past WORDS and reserved field: ignored, read zero.
        pio_write(5, 0, 9, 32'h1234_5678);
        pio_read(5, 0, 9, rd_val);
        chk("oor_word_rd", rd_val, 32'h0);
        pio_write(5, 3, 0, 32'h1234_5678);
        pio_read(5, 3, 0, rd_val);
        chk("rsvd_rd", rd_val, 32'h0);

        // rd and wr together: write wins, rddata holds, one ack.
        @(negedge clk);
        pio_oftcam_wr     = 1'b1;
        pio_oftcam_rd     = 1'b1;
        pio_oftcam_addr   = {8'd5, 2'd0, 6'd8};
        pio_oftcam_wrdata = 32'h0000_0ABC;
        @(negedge clk);
        chk("rdwr_ack", 32'(oftcam_pio_ack), 32'd1);
        chk("rdwr_rddata_hold", oftcam_pio_rddata, 32'h0);
        pio_oftcam_wr = 1'b0;
        pio_oftcam_rd = 1'b0;
        @(negedge clk);
        chk("rdwr_ack_single", 32'(oftcam_pio_ack), 32'd0);
        pio_read(5, 0, 8, rd_val);
        chk("rdwr_written", rd_val, 32'h0000_0ABC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
